// File: rtl/avr_addr_loader_if.sv
// rtl/avr_addr_loader_if.sv - AVR serial address link and committed-address outputs
interface avr_addr_loader_if #(
    parameter int ADDR_W = 21
);
    logic              avr_si;
    logic              avr_sclk;
    logic              avr_sreg_en;
    logic              avr_counter;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        output avr_si, avr_sclk, avr_sreg_en, avr_counter,
        input  addr, addr_valid, busy, frame_err
    );

    modport slave (
        input  avr_si, avr_sclk, avr_sreg_en, avr_counter,
        output addr, addr_valid, busy, frame_err
    );
endinterface

// File: rtl/avr_addr_loader.sv
// rtl/avr_addr_loader.sv - serial SRAM address loader with post-increment for the AVR bus FSM
module avr_addr_loader #(
    parameter int ADDR_W      = 21,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             reset,
    avr_addr_loader_if.slave bus
);
    localparam int CNT_W = $clog2(ADDR_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] si_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] cnt_sync;
    logic                   sclk_hist;
    logic                   en_hist;
    logic                   cnt_hist;

    logic [ADDR_W-1:0] shift_buf;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_valid_q;
    logic              busy_q;
    logic              frame_err_q;

    logic si_s;
    logic sclk_s;
    logic en_s;
    logic cnt_s;
    logic sclk_rise;
    logic en_fall;
    logic en_rise;
    logic cnt_fall;

    assign si_s   = si_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign en_s   = en_sync[SYNC_STAGES-1];
    assign cnt_s  = cnt_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist;
    assign en_fall   = ~en_s & en_hist;
    assign en_rise   = en_s & ~en_hist;
    assign cnt_fall  = ~cnt_s & cnt_hist;

    // Synchronizers reset to the inactive level of each AVR line so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            si_sync   <= '0;
            sclk_sync <= '0;
            en_sync   <= '1;
            cnt_sync  <= '1;
            sclk_hist <= 1'b0;
            en_hist   <= 1'b1;
            cnt_hist  <= 1'b1;
        end else begin
            si_sync   <= {si_sync[SYNC_STAGES-2:0], bus.avr_si};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.avr_sclk};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], bus.avr_sreg_en};
            cnt_sync  <= {cnt_sync[SYNC_STAGES-2:0], bus.avr_counter};
            sclk_hist <= sclk_s;
            cnt_hist  <= cnt_s;
            // Freezing the enable history through COMMIT keeps a new frame-open edge pending for IDLE.
            if (state != COMMIT) begin
                en_hist <= en_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_buf    <= '0;
            bit_cnt      <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_fall) begin
                        state     <= SHIFT;
                        shift_buf <= '0;
                        bit_cnt   <= '0;
                        busy_q    <= 1'b1;
                    end else if (cnt_fall) begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_buf <= {shift_buf[ADDR_W-2:0], si_s};
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                    if (en_rise) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (bit_cnt == CNT_FULL) begin
                        addr_q       <= shift_buf;
                        addr_valid_q <= 1'b1;
                        frame_err_q  <= 1'b0;
                    end else begin
                        frame_err_q  <= 1'b1;
                    end
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_avr_addr_loader.sv
// tb/tb_avr_addr_loader.sv - directed scoreboard bench for avr_addr_loader
module tb_avr_addr_loader;
    localparam int ADDR_W = 21;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              valid;
        logic              err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;

    exp_t sb[$];
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_valid = 1'b0;
    logic              m_err = 1'b0;

    avr_addr_loader_if #(.ADDR_W(ADDR_W)) bus ();

    avr_addr_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.addr  = m_addr;
        e.valid = m_valid;
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_addr"}, 32'(bus.addr), 32'(e.addr));
            chk({tag, "_valid"}, 32'(bus.addr_valid), 32'(e.valid));
            chk({tag, "_err"}, 32'(bus.frame_err), 32'(e.err));
        end
    endtask

    task automatic send_bit(input logic b);
        bus.avr_si = b;
        wait_neg(1);
        bus.avr_sclk = 1'b1;
        wait_neg(4);
        bus.avr_sclk = 1'b0;
        wait_neg(4);
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 12) begin
            wait_neg(1);
            n++;
        end
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    endtask

    // pulse_bit >= 0 drops avr_counter around that bit; commit_pulse times a fall into COMMIT
    task automatic send_frame(input string tag, input logic [31:0] val, input int nbits,
                              input int pulse_bit, input bit commit_pulse);
        bus.avr_sreg_en = 1'b0;
        wait_neg(4);
        chk({tag, "_busy_open"}, 32'(bus.busy), 32'd1);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i == pulse_bit) begin
                bus.avr_counter = 1'b0;
                wait_neg(4);
                bus.avr_counter = 1'b1;
                wait_neg(4);
            end
            send_bit(val[i]);
        end
        if (nbits == ADDR_W) begin
            m_addr  = val[ADDR_W-1:0];
            m_valid = 1'b1;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        push_model();
        bus.avr_sreg_en = 1'b1;
        if (commit_pulse) begin
            wait_neg(1);
            bus.avr_counter = 1'b0;
        end
        wait_neg(2);
        wait_not_busy(tag);
        if (commit_pulse) begin
            wait_neg(2);
            bus.avr_counter = 1'b1;
            wait_neg(4);
        end
        pop_check(tag);
    endtask

    task automatic pulse_counter(input string tag);
        m_addr = m_addr + ADDR_W'(1);
        push_model();
        bus.avr_counter = 1'b0;
        wait_neg(4);
        bus.avr_counter = 1'b1;
        wait_neg(4);
        pop_check(tag);
    endtask

    initial begin
        bus.avr_si      = 1'b0;
        bus.avr_sclk    = 1'b0;
        bus.avr_sreg_en = 1'b1;
        bus.avr_counter = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        wait_neg(10);
        push_model();
        pop_check("reset");
        chk("reset_busy", 32'(bus.busy), 32'd0);

        send_frame("frame_19999f", 32'h19999F, 21, -1, 1'b0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        send_frame("frame_1ffffe", 32'h1FFFFE, 21, -1, 1'b0);
        pulse_counter("inc_1fffff");
        pulse_counter("inc_wrap");
        pulse_counter("inc_000001");

        send_frame("short_20", 32'h0ABCD, 20, -1, 1'b0);
        send_frame("long_22", 32'h2AAAAA, 22, -1, 1'b0);
        send_frame("frame_0abcde", 32'h0ABCDE, 21, -1, 1'b0);

        send_frame("frame_no_inc", 32'h155AA3, 21, 10, 1'b1);
        pulse_counter("inc_after_commit");

        bus.avr_sreg_en = 1'b0;
        wait_neg(4);
        for (int i = 20; i >= 11; i--) begin
            send_bit(1'b1);
        end
        chk("mid_frame_addr_frozen", 32'(bus.addr), 32'(m_addr));
        reset = 1'b1;
        bus.avr_sreg_en = 1'b1;
        bus.avr_sclk = 1'b0;
        m_addr  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        push_model();
        wait_neg(1);
        reset = 1'b0;
        pop_check("mid_reset");
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
        wait_neg(6);
        send_frame("frame_000055", 32'h000055, 21, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
